mux4_rr_arbiter: RTL and testbench
==================================

# mux4_rr_arbiter

Round-robin arbiter and sequencer that shares one WIDTH-bit output channel between four requesters, driving the 4:1 select of the team's byte multiplexer. Each requester holds a request while it has data. The block grants one requester at a time for a bounded burst of handshaked beats, then rotates priority. It sits between four producer ports and a single downstream consumer with valid/ready flow control.

## Interface
- WIDTH, 8, data width of every requester and of the output channel
- MAX_BURST, 4, maximum beats per grant; legal range 1..255

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- req  input  4  per-requester request; bit i = requester i has data
- in_data  input  4*WIDTH  packed requester data; requester i at [i*WIDTH +: WIDTH]
- out_ready  input  1  downstream accepts a beat this cycle
- gnt  output  4  one-hot grant, registered; all zero when idle
- sel  output  2  registered index of the granted requester (mux select)
- out_valid  output  1  beat offered downstream
- out_data  output  WIDTH  in_data slice selected by sel

## Operation
- FSM states: IDLE, GRANT. Registers: state, sel, gnt, ptr (2-bit priority pointer), cnt (8-bit beat count).
- IDLE: if req != 0, pick the first i with req[i]=1, scanning ptr, ptr+1, ptr+2, ptr+3 mod 4.
  - On that edge: sel<=i, gnt<=1<<i, cnt<=0, state<=GRANT.
  - If req == 0, stay in IDLE with gnt=0.
- GRANT:
  - out_valid = req[sel] (combinational), forced 0 outside GRANT.
  - out_data = in_data slice for sel (combinational, always driven).
  - Beat = out_valid && out_ready; each beat increments cnt.
- Release conditions (either ends the burst):
  - req[sel]=0 in GRANT.
  - A beat occurs with cnt == MAX_BURST-1.
- On release edge: state<=IDLE, gnt<=0, ptr<=sel+1 mod 4. cnt and sel hold their values.
- The requester identifies a consumed beat as gnt[i] && out_ready && req[i]. It must present the next word in the cycle after each consumed beat.
- Requests from non-granted requesters are ignored during GRANT, including new assertions.

## Timing
- Reset (async assert, released synchronously to clk): state=IDLE, gnt=0, sel=0, ptr=0, cnt=0, out_valid=0, out_data=in_data[WIDTH-1:0].
- Latency: req[i] high at edge N (IDLE) -> gnt[i] and out_valid high after edge N; the first beat can complete at edge N+1.
- Throughput in a burst: one beat per cycle while out_ready=1. After release, one mandatory IDLE arbitration cycle occurs before the next grant. Peak rate is MAX_BURST beats per MAX_BURST+1 cycles.
- Backpressure: out_ready=0 holds cnt, gnt and sel. out_data stays equal to the granted slice. There is no timeout.
- req[sel] drops in the same cycle out_ready=1: no beat is counted; release occurs on that edge.
- MAX_BURST=1: every beat releases. Grants rotate on every beat plus one idle cycle.
- ptr wrap: after grant 3, ptr=0.
- Reset mid-burst: gnt, out_valid, state and ptr clear immediately. The beat in flight is not counted as transferred.

## Test plan
- Single requester, WIDTH=8, MAX_BURST=4, out_ready=1, req=0010, in_data[15:8]=BB:
  - gnt=0010, sel=01, out_data=BB, 4 beats on consecutive edges.
  - Then 1 cycle gnt=0000, then regrant to 0010.
- All requesting, req=1111, data AA/BB/CC/DD:
  - Grant order is 0,1,2,3,0, each 4 beats long.
  - out_data sequence is AA×4, BB×4, CC×4, DD×4, AA×4, with one idle cycle between bursts.
- Backpressure: out_ready=0 for 3 cycles mid-burst after 2 beats.
  - cnt stays 2, gnt/sel/out_data stable.
  - Burst completes with 2 more beats after out_ready returns to 1.
- Early drop: requester 1 drops req after 2 beats.
  - Release on the drop edge, ptr=2.
  - With req=1001 pending, requester 3 is granted next, ahead of requester 0.
- Reset mid-burst: rst_n low during requester 2's burst at beat 1.
  - gnt=0000, out_valid=0 immediately.
  - After release of reset with req=1111, the first grant goes to requester 0.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter/sequencer sharing one WIDTH-bit valid/ready channel between
// four requesters; grants bounded bursts of up to MAX_BURST beats, then rotates.
module mux4_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           req,
  input  logic [4*WIDTH-1:0]   in_data,
  input  logic                 out_ready,
  output logic [3:0]           gnt,
  output logic [1:0]           sel,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t      state, state_d;
  logic [1:0]  sel_d;
  logic [3:0]  gnt_d;
  logic [1:0]  ptr, ptr_d;
  logic [7:0]  cnt, cnt_d;
  logic [1:0]  pick;
  logic        beat;
  logic        last_beat;

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    pick = ptr;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr + 2'(k)]) begin
        pick = ptr + 2'(k);
      end
    end
  end

  always_comb begin
    out_data = in_data[WIDTH-1:0];
    case (sel)
      2'd0:    out_data = in_data[0*WIDTH +: WIDTH];
      2'd1:    out_data = in_data[1*WIDTH +: WIDTH];
      2'd2:    out_data = in_data[2*WIDTH +: WIDTH];
      default: out_data = in_data[3*WIDTH +: WIDTH];
    endcase
  end

  assign out_valid = (state == GRANT) && req[sel];
  assign beat      = out_valid && out_ready;
  assign last_beat = (cnt == 8'(MAX_BURST - 1));

  always_comb begin
    state_d = state;
    sel_d   = sel;
    gnt_d   = gnt;
    ptr_d   = ptr;
    cnt_d   = cnt;
    case (state)
      IDLE: begin
        gnt_d = 4'b0000;
        if (|req) begin
          sel_d   = pick;
          gnt_d   = 4'b0001 << pick;
          cnt_d   = 8'd0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // A dropped request ends the burst without counting a beat that edge.
        if (!req[sel] || (beat && last_beat)) begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
          ptr_d   = sel + 2'd1;
        end else if (beat) begin
          cnt_d = cnt + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel   <= 2'd0;
      gnt   <= 4'b0000;
      ptr   <= 2'd0;
      cnt   <= 8'd0;
    end else begin
      state <= state_d;
      sel   <= sel_d;
      gnt   <= gnt_d;
      ptr   <= ptr_d;
      cnt   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: a behavioural model predicts every grant
// and every beat; a negedge monitor pops expected beats when the DUT hands one off.
module tb_mux4_rr_arbiter;
  localparam int WIDTH     = 8;
  localparam int MAX_BURST = 4;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [3:0]          req = 4'b0000;
  logic [4*WIDTH-1:0]  in_data = '0;
  logic                out_ready = 1'b0;
  logic [3:0]          gnt;
  logic [1:0]          sel;
  logic                out_valid;
  logic [WIDTH-1:0]    out_data;

  mux4_rr_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .in_data(in_data), .out_ready(out_ready),
    .gnt(gnt), .sel(sel), .out_valid(out_valid), .out_data(out_data)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]       who;
    logic [WIDTH-1:0] data;
  } beat_t;

  beat_t            beat_q[$];
  int               checks = 0;
  int               fails  = 0;
  logic [3:0]       exp_gnt   = 4'b0000;
  logic             exp_valid = 1'b0;
  logic [1:0]       exp_sel   = 2'd0;
  bit               exp_check = 1'b0;

  // Reference model: who owns the channel, how many beats it has had, whose turn is next.
  bit               m_busy  = 1'b0;
  int               m_owner = 0;
  int               m_count = 0;
  int               m_ptr   = 0;
  logic [WIDTH-1:0] word[4];
  int               refresh   = -1;
  bit               rand_data = 1'b0;
  int               remaining[4];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // Drives one cycle of inputs, predicts what the DUT does on the coming edge, then steps.
  task automatic applyStimulus(input logic [3:0] r, input logic rdy);
    beat_t b;
    if (rand_data && refresh >= 0) word[refresh] = WIDTH'($urandom);
    refresh = -1;
    req = r;
    out_ready = rdy;
    for (int i = 0; i < 4; i++) in_data[i*WIDTH +: WIDTH] = word[i];
    exp_gnt   = m_busy ? 4'(1 << m_owner) : 4'b0000;
    exp_valid = m_busy && r[m_owner];
    exp_sel   = 2'(m_owner);
    if (m_busy) begin
      if (!r[m_owner]) begin
        m_busy = 1'b0;
        m_ptr  = (m_owner + 1) % 4;
      end else if (rdy) begin
        b.who  = 2'(m_owner);
        b.data = word[m_owner];
        beat_q.push_back(b);
        refresh = m_owner;
        m_count++;
        if (m_count == MAX_BURST) begin
          m_busy = 1'b0;
          m_ptr  = (m_owner + 1) % 4;
        end
      end
    end else if (r != 4'b0000) begin
      for (int k = 0; k < 4; k++) begin
        if (r[(m_ptr + k) % 4]) begin
          m_busy  = 1'b1;
          m_owner = (m_ptr + k) % 4;
          m_count = 0;
          break;
        end
      end
    end
    exp_check = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic resetMidBurst(input logic [3:0] r);
    req = r;
    rst_n = 1'b0;
    exp_check = 1'b0;
    #1;
    checkOutput("reset_gnt", 32'(gnt), 32'(4'b0000));
    checkOutput("reset_out_valid", 32'(out_valid), 32'(1'b0));
    checkOutput("reset_queue_drained", 32'(beat_q.size()), 32'd0);
    beat_q.delete();
    m_busy = 1'b0;
    m_ptr  = 0;
    refresh = -1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (exp_check) begin
      beat_t e;
      checkOutput("gnt", 32'(gnt), 32'(exp_gnt));
      checkOutput("out_valid", 32'(out_valid), 32'(exp_valid));
      if (exp_gnt != 4'b0000) checkOutput("sel", 32'(sel), 32'(exp_sel));
      if (out_valid && out_ready) begin
        if (beat_q.size() == 0) begin
          checkOutput("beat_expected", 32'd1, 32'd0);
        end else begin
          e = beat_q.pop_front();
          checkOutput("beat_sel", 32'(sel), 32'(e.who));
          checkOutput("beat_data", 32'(out_data), 32'(e.data));
        end
      end
    end
  end

  initial begin
    logic [3:0] r;
    word[0] = 8'hAA; word[1] = 8'hBB; word[2] = 8'hCC; word[3] = 8'hDD;
    for (int i = 0; i < 4; i++) begin
      in_data[i*WIDTH +: WIDTH] = word[i];
      remaining[i] = 0;
    end
    #1;
    checkOutput("init_gnt", 32'(gnt), 32'(4'b0000));
    checkOutput("init_sel", 32'(sel), 32'd0);
    checkOutput("init_out_valid", 32'(out_valid), 32'(1'b0));
    checkOutput("init_out_data", 32'(out_data), 32'(8'hAA));
    #20;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    $display("[TB] single requester");
    repeat (12) applyStimulus(4'b0010, 1'b1);
    repeat (2) applyStimulus(4'b0000, 1'b1);

    $display("[TB] all requesting");
    repeat (26) applyStimulus(4'b1111, 1'b1);
    repeat (2) applyStimulus(4'b0000, 1'b1);

    $display("[TB] backpressure");
    repeat (3) applyStimulus(4'b0100, 1'b1);
    repeat (3) applyStimulus(4'b0100, 1'b0);
    repeat (3) applyStimulus(4'b0100, 1'b1);
    repeat (2) applyStimulus(4'b0000, 1'b1);

    $display("[TB] early drop");
    repeat (3) applyStimulus(4'b0010, 1'b1);
    repeat (6) applyStimulus(4'b1001, 1'b1);
    repeat (2) applyStimulus(4'b0000, 1'b1);

    $display("[TB] reset mid-burst");
    repeat (2) applyStimulus(4'b0100, 1'b1);
    resetMidBurst(4'b1111);
    repeat (6) applyStimulus(4'b1111, 1'b1);
    repeat (2) applyStimulus(4'b0000, 1'b1);

    $display("[TB] random traffic");
    rand_data = 1'b1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (remaining[i] == 0 && $urandom_range(0, 9) == 0) remaining[i] = $urandom_range(1, 10);
        else if (remaining[i] > 0 && $urandom_range(0, 49) == 0) remaining[i] = 0;
        r[i] = (remaining[i] > 0);
      end
      applyStimulus(r, ($urandom_range(0, 3) != 0));
      if (refresh >= 0) remaining[refresh]--;
    end

    repeat (4) applyStimulus(4'b0000, 1'b1);
    checkOutput("final_queue_drained", 32'(beat_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
